// File: rtl/ain_conditioner_if.sv
// ain_conditioner_if: switch input and debounced-code outputs of the analog-input conditioner.
`default_nettype none

interface ain_conditioner_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       sw;
    logic [1:0]       ain;
    logic             ain_chg;
    logic             busy;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output sw,
        input  ain,
        input  ain_chg,
        input  busy,
        input  chg_cnt
    );

    modport slave (
        input  sw,
        output ain,
        output ain_chg,
        output busy,
        output chg_cnt
    );
endinterface

`default_nettype wire

// File: rtl/ain_conditioner.sv
// ==========================================================================
// Module      : ain_conditioner
// Description : Two-flop synchronizer plus 2-bit vector debouncer producing a
//               registered code, a commit pulse, a busy flag and commit count.
// Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module ain_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    ain_conditioner_if.slave    bus
);

    localparam int               c_CW       = (DEB_CYCLES <= 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [c_CW-1:0]  c_CNT_MAX  = c_CW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CHG_SAT  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_cand;
    logic [c_CW-1:0]  r_cnt;
    logic [1:0]       r_ain;
    logic             r_ain_chg;
    logic             r_busy;
    logic [CNT_W-1:0] r_chg_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_s1      <= 2'b00;
            r_s2      <= 2'b00;
            r_cand    <= 2'b00;
            r_cnt     <= '0;
            r_ain     <= 2'b00;
            r_ain_chg <= 1'b0;
            r_busy    <= 1'b0;
            r_chg_cnt <= '0;
        end else begin
            r_s1      <= bus.sw;
            r_s2      <= r_s1;
            r_ain_chg <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_s2 != r_ain) begin
                        r_cand  <= r_s2;
                        r_state <= ST_SETTLE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Bounce back to the committed code wins over every other case.
                    if (r_s2 == r_ain) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_s2 != r_cand) begin
                        r_cand <= r_s2;
                        r_cnt  <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_ain     <= r_cand;
                        r_ain_chg <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        if (r_chg_cnt != c_CHG_SAT) begin
                            r_chg_cnt <= r_chg_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ain     = r_ain;
    assign bus.ain_chg = r_ain_chg;
    assign bus.busy    = r_busy;
    assign bus.chg_cnt = r_chg_cnt;

endmodule

`default_nettype wire
